// File: rtl/phy_tx_sched.sv
// Transmit scheduler for the PHY TX path: COM training, TLP/idle arbitration,
// and periodic SKP ordered-set insertion at packet boundaries.
module phy_tx_sched #(
  parameter int unsigned TRAIN_WORDS  = 8,
  parameter int unsigned SKP_INTERVAL = 16,
  parameter logic [7:0]  COM_SYM      = 8'hBC,
  parameter logic [7:0]  SKP_SYM      = 8'h1C,
  parameter logic [7:0]  IDL_SYM      = 8'h7C
) (
  input  logic        clk_f,
  input  logic        reset,
  input  logic        en,
  input  logic [31:0] tlp_data,
  input  logic        tlp_valid,
  input  logic        tlp_last,
  output logic        tlp_ready,
  output logic [31:0] data_out,
  output logic        valid_out,
  output logic        link_up,
  output logic        skp_sent,
  output logic        underrun_err
);

  localparam int unsigned TcW = (TRAIN_WORDS > 1) ? $clog2(TRAIN_WORDS) : 1;
  localparam int unsigned ScW = $clog2(SKP_INTERVAL);

  localparam logic [TcW-1:0] TrainLast = TcW'(TRAIN_WORDS - 1);
  localparam logic [ScW-1:0] SkpLast   = ScW'(SKP_INTERVAL - 1);

  localparam logic [31:0] ComWord = {4{COM_SYM}};
  localparam logic [31:0] IdlWord = {4{IDL_SYM}};
  localparam logic [31:0] SkpWord = {SKP_SYM, SKP_SYM, SKP_SYM, COM_SYM};

  typedef enum logic [2:0] {StOff, StTrain, StIdle, StData, StSkp} state_e;

  state_e         st_q, st_d;
  logic [TcW-1:0] train_q, train_d;
  logic [ScW-1:0] cnt_q, cnt_d;
  logic           pend_q, pend_d;
  logic           underrun_q, underrun_d;
  logic [31:0]    data_q, data_d;
  logic           valid_q, valid_d;
  logic           link_q, link_d;
  logic           sent_q, sent_d;
  logic           emit_cnt;

  always_comb begin
    case (st_q)
      StIdle:  tlp_ready = en & ~pend_q;
      StData:  tlp_ready = 1'b1;
      default: tlp_ready = 1'b0;
    endcase
  end

  always_comb begin
    st_d       = st_q;
    train_d    = train_q;
    cnt_d      = cnt_q;
    pend_d     = pend_q;
    underrun_d = underrun_q;
    data_d     = '0;
    valid_d    = 1'b0;
    sent_d     = 1'b0;
    emit_cnt   = 1'b0;

    case (st_q)
      StOff: begin
        if (en) begin
          st_d    = StTrain;
          train_d = '0;
        end
      end
      StTrain: begin
        if (!en) begin
          st_d = StOff;
        end else begin
          valid_d = 1'b1;
          data_d  = ComWord;
          if (train_q == TrainLast) st_d = StIdle;
          else                      train_d = train_q + 1'b1;
        end
      end
      StIdle: begin
        if (!en) begin
          st_d = StOff;
        end else if (pend_q) begin
          valid_d = 1'b1;
          data_d  = SkpWord;
          sent_d  = 1'b1;
          pend_d  = 1'b0;
          cnt_d   = '0;
          st_d    = StSkp;
        end else begin
          valid_d  = 1'b1;
          emit_cnt = 1'b1;
          if (tlp_valid) begin
            data_d = tlp_data;
            if (!tlp_last) st_d = StData;
          end else begin
            data_d = IdlWord;
          end
        end
      end
      StSkp: begin
        // Ready is held low here, so the only possible word is idle fill.
        if (!en) begin
          st_d = StOff;
        end else begin
          valid_d  = 1'b1;
          emit_cnt = 1'b1;
          data_d   = IdlWord;
          st_d     = StIdle;
        end
      end
      StData: begin
        valid_d  = 1'b1;
        emit_cnt = 1'b1;
        if (tlp_valid) begin
          data_d = tlp_data;
          if (tlp_last) st_d = StIdle;
        end else begin
          data_d     = IdlWord;
          underrun_d = 1'b1;
        end
      end
      default: st_d = StOff;
    endcase

    // Counter saturates at the threshold; the pending flag holds until a boundary.
    if (emit_cnt) begin
      if (cnt_q != SkpLast) cnt_d = cnt_q + 1'b1;
      if (cnt_q + 1'b1 == SkpLast) pend_d = 1'b1;
    end

    if (st_d == StOff) begin
      cnt_d  = '0;
      pend_d = 1'b0;
    end

    link_d = ((st_q == StIdle) || (st_q == StData) || (st_q == StSkp)) && (st_d != StOff);
  end

  always_ff @(posedge clk_f) begin
    if (reset) begin
      st_q       <= StOff;
      train_q    <= '0;
      cnt_q      <= '0;
      pend_q     <= 1'b0;
      underrun_q <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      link_q     <= 1'b0;
      sent_q     <= 1'b0;
    end else begin
      st_q       <= st_d;
      train_q    <= train_d;
      cnt_q      <= cnt_d;
      pend_q     <= pend_d;
      underrun_q <= underrun_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      link_q     <= link_d;
      sent_q     <= sent_d;
    end
  end

  assign data_out     = data_q;
  assign valid_out    = valid_q;
  assign link_up      = link_q;
  assign skp_sent     = sent_q;
  assign underrun_err = underrun_q;

endmodule

// File: tb/tb_phy_tx_sched.sv
// Randomised bench for phy_tx_sched, checked cycle by cycle against a
// word-level model of the link (training, packets, idle fill, SKP cadence).
module tb_phy_tx_sched;

  localparam int unsigned TW = 8;
  localparam int unsigned SI = 16;
  localparam logic [31:0] ComW = 32'hBCBCBCBC;
  localparam logic [31:0] IdlW = 32'h7C7C7C7C;
  localparam logic [31:0] SkpW = 32'h1C1C1CBC;

  logic        clk_f = 1'b0;
  logic        reset, en, tlp_valid, tlp_last;
  logic [31:0] tlp_data, data_out;
  logic        tlp_ready, valid_out, link_up, skp_sent, underrun_err;

  always #5 clk_f = ~clk_f;

  phy_tx_sched #(.TRAIN_WORDS(TW), .SKP_INTERVAL(SI)) dut (
    .clk_f       (clk_f),
    .reset       (reset),
    .en          (en),
    .tlp_data    (tlp_data),
    .tlp_valid   (tlp_valid),
    .tlp_last    (tlp_last),
    .tlp_ready   (tlp_ready),
    .data_out    (data_out),
    .valid_out   (valid_out),
    .link_up     (link_up),
    .skp_sent    (skp_sent),
    .underrun_err(underrun_err)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Link model: mode 0 = down, 1 = training, 2 = linked.
  int          m_mode = 0;
  int          m_trained = 0;
  int          m_since = 0;
  bit          m_in_pkt = 0, m_due = 0, m_after_skp = 0, m_under = 0;
  logic [31:0] e_data;
  bit          e_valid, e_link, e_sent;

  // Packet source
  logic [31:0] src_w[$];
  bit          src_l[$];

  function automatic bit m_ready();
    if (m_mode != 2) return 1'b0;
    if (m_in_pkt) return 1'b1;
    return en && !m_due && !m_after_skp;
  endfunction

  function automatic void m_emit(input logic [31:0] w);
    e_valid = 1'b1;
    e_data  = w;
    m_since = (m_since < SI - 1) ? m_since + 1 : SI - 1;
    if (m_since == SI - 1) m_due = 1'b1;
  endfunction

  function automatic void m_step();
    bit was_linked = (m_mode == 2);
    e_data = '0; e_valid = 1'b0; e_sent = 1'b0;
    if (reset) begin
      m_mode = 0; m_trained = 0; m_since = 0;
      m_in_pkt = 0; m_due = 0; m_after_skp = 0; m_under = 0;
      was_linked = 1'b0;
    end else if (m_mode == 0) begin
      if (en) begin m_mode = 1; m_trained = 0; end
    end else if (m_mode == 1) begin
      if (!en) m_mode = 0;
      else begin
        e_valid = 1'b1; e_data = ComW;
        m_trained++;
        if (m_trained == TW) begin m_mode = 2; m_in_pkt = 0; m_after_skp = 0; end
      end
    end else if (m_in_pkt) begin
      if (tlp_valid) begin
        m_emit(tlp_data);
        if (tlp_last) m_in_pkt = 0;
      end else begin
        m_emit(IdlW);
        m_under = 1'b1;
      end
    end else if (!en) begin
      m_mode = 0; m_since = 0; m_due = 0; m_after_skp = 0;
    end else if (m_due) begin
      e_valid = 1'b1; e_data = SkpW; e_sent = 1'b1;
      m_due = 0; m_since = 0; m_after_skp = 1;
    end else if (m_after_skp) begin
      m_emit(IdlW);
      m_after_skp = 0;
    end else if (tlp_valid) begin
      m_emit(tlp_data);
      if (!tlp_last) m_in_pkt = 1;
    end else begin
      m_emit(IdlW);
    end
    e_link = was_linked && (m_mode == 2);
  endfunction

  // One clock: check ready, advance model, compare registered outputs after the edge.
  task automatic cycle(output bit xfer);
    bit rdy;
    #1;
    rdy  = m_ready();
    xfer = !reset && tlp_valid && rdy;
    if (!reset) check_eq("tlp_ready", {31'b0, tlp_ready}, {31'b0, rdy});
    m_step();
    @(posedge clk_f);
    #1;
    check_eq("data_out", data_out, e_data);
    check_eq("valid_out", {31'b0, valid_out}, {31'b0, e_valid});
    check_eq("link_up", {31'b0, link_up}, {31'b0, e_link});
    check_eq("skp_sent", {31'b0, skp_sent}, {31'b0, e_sent});
    check_eq("underrun_err", {31'b0, underrun_err}, {31'b0, m_under});
  endtask

  task automatic add_pkt(input int len);
    for (int i = 0; i < len; i++) begin
      src_w.push_back($urandom);
      src_l.push_back(i == len - 1);
    end
  endtask

  // Present the head of the source (or a bubble), clock once, pop on handshake.
  task automatic src_cycle(input bit allow);
    bit xfer;
    if (allow && src_w.size() != 0) begin
      tlp_valid = 1'b1;
      tlp_data  = src_w[0];
      tlp_last  = src_l[0];
    end else begin
      tlp_valid = 1'b0;
      tlp_data  = $urandom;
      tlp_last  = 1'($urandom_range(0, 1));
    end
    cycle(xfer);
    if (xfer) begin
      void'(src_w.pop_front());
      void'(src_l.pop_front());
    end
  endtask

  int first_valid, com_cnt, skp_cnt_seen;

  initial begin
    reset = 1'b1; en = 1'b0; tlp_valid = 1'b0; tlp_last = 1'b0; tlp_data = '0;
    repeat (2) src_cycle(1'b0);
    check_eq("reset_data", data_out, 32'h0);
    reset = 1'b0; en = 1'b1;

    // Bring-up: first valid word on edge 2, eight COM words.
    first_valid = 0; com_cnt = 0;
    for (int c = 1; c <= 12; c++) begin
      src_cycle(1'b0);
      if (valid_out && first_valid == 0) first_valid = c;
      if (valid_out && data_out == ComW) com_cnt++;
    end
    check_eq("t1_first_valid", first_valid, 2);
    check_eq("t1_com_words", com_cnt, TW);
    check_eq("t1_link_up", {31'b0, link_up}, 32'd1);

    // Idle stretch must contain exactly one SKP.
    skp_cnt_seen = 0;
    for (int c = 0; c < 20; c++) begin
      src_cycle(1'b0);
      if (skp_sent) begin
        skp_cnt_seen++;
        check_eq("t3_skp_word", data_out, SkpW);
      end
    end
    check_eq("t3_skp_pulses", skp_cnt_seen, 1);

    // Short packet, then 10-word packets that straddle the SKP threshold.
    add_pkt(3);
    repeat (6) src_cycle(1'b1);
    for (int p = 0; p < 4; p++) begin
      add_pkt(10);
      repeat (14) src_cycle(1'b1);
    end

    // Underrun: two bubbles mid-packet.
    add_pkt(6);
    repeat (2) src_cycle(1'b1);
    repeat (2) src_cycle(1'b0);
    check_eq("t5_underrun", {31'b0, underrun_err}, 32'd1);
    repeat (10) src_cycle(1'b1);
    check_eq("t5_underrun_sticky", {31'b0, underrun_err}, 32'd1);

    // Reset during a packet; retrain afterwards.
    add_pkt(8);
    repeat (3) src_cycle(1'b1);
    reset = 1'b1;
    src_cycle(1'b1);
    src_w.delete(); src_l.delete();
    check_eq("t6_valid", {31'b0, valid_out}, 32'd0);
    check_eq("t6_link", {31'b0, link_up}, 32'd0);
    check_eq("t6_underrun", {31'b0, underrun_err}, 32'd0);
    reset = 1'b0;
    com_cnt = 0;
    for (int c = 0; c < 12; c++) begin
      src_cycle(1'b0);
      if (valid_out && data_out == ComW) com_cnt++;
    end
    check_eq("t6_retrain_com", com_cnt, TW);

    // Random traffic with gaps and occasional link drops.
    for (int c = 0; c < 2000; c++) begin
      if ($urandom_range(0, 99) < 2) en = ~en;
      else if (!en && $urandom_range(0, 99) < 20) en = 1'b1;
      if (src_w.size() == 0 && $urandom_range(0, 99) < 30) add_pkt($urandom_range(1, 12));
      src_cycle($urandom_range(0, 99) >= 8);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
